// File: rtl/bt656_video_tx.sv
// BT.656 525-line 8-bit 4:2:2 transmitter: inserts EAV/SAV codes, blanking fill and
// sync strobes around an upstream pixel stream accepted on a ready/valid handshake.
module bt656_video_tx #(
  parameter int H_ACTIVE_PIX  = 720,
  parameter int H_BLANK_BYTES = 268,
  parameter int V_TOTAL       = 525,
  parameter int F1_START      = 4,
  parameter int F2_START      = 266,
  parameter int V1_START      = 20,
  parameter int V1_END        = 263,
  parameter int V2_START      = 283,
  parameter int HS_BYTES      = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        uflow_clr,
  output logic [7:0]  td_data,
  output logic        td_hs,
  output logic        td_vs,
  output logic        frame_start,
  output logic        uflow
);

  localparam int H_TOTAL   = 8 + H_BLANK_BYTES + 2 * H_ACTIVE_PIX;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int LW        = $clog2(V_TOTAL + 1);
  localparam int SAV_START = 4 + H_BLANK_BYTES;
  localparam int ACT_START = SAV_START + 4;
  localparam logic [1:0] SAV_LO  = 2'(SAV_START);
  localparam logic       ACT_PAR = ((ACT_START % 2) == 1);

  typedef enum logic [1:0] {ST_EAV, ST_HBLANK, ST_SAV, ST_ACTIVE} state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [LW-1:0]   line_q, line_d;
  logic [7:0]      data_q, data_d;
  logic [7:0]      y_q, y_d;
  logic            have_q, have_d;
  logic            hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, uflow_q, uflow_d;

  logic            f_cur, v_cur, h_bit, act_odd, last_h;
  logic [1:0]      code_idx;
  logic [7:0]      xy;

  // 00 and FF are reserved for timing-code preambles.
  function automatic logic [7:0] clamp(input logic [7:0] b);
    if (b == 8'h00) return 8'h01;
    if (b == 8'hFF) return 8'hFE;
    return b;
  endfunction

  always_comb begin
    state_d  = state_q;
    data_d   = 8'h80;
    y_d      = y_q;
    have_d   = have_q;
    uflow_d  = uflow_q & ~uflow_clr;

    f_cur    = (line_q < LW'(F1_START)) || (line_q >= LW'(F2_START));
    v_cur    = (line_q < LW'(V1_START)) ||
               ((line_q > LW'(V1_END)) && (line_q < LW'(V2_START)));
    h_bit    = (state_q == ST_EAV);
    code_idx = h_bit ? h_q[1:0] : (h_q[1:0] - SAV_LO);
    xy       = {1'b1, f_cur, v_cur, h_bit, v_cur ^ h_bit, f_cur ^ h_bit,
                f_cur ^ v_cur, f_cur ^ v_cur ^ h_bit};
    act_odd  = h_q[0] ^ ACT_PAR;
    pix_ready = (state_q == ST_ACTIVE) && !v_cur && !act_odd;

    last_h = (h_q == HW'(H_TOTAL - 1));
    h_d    = last_h ? '0 : h_q + 1'b1;
    line_d = line_q;
    if (last_h) line_d = (line_q == LW'(V_TOTAL)) ? LW'(1) : line_q + 1'b1;

    hs_d = !(int'(h_q) < HS_BYTES);
    vs_d = (h_q == '0) ? !v_cur : vs_q;
    fs_d = (h_q == '0) && (line_q == LW'(1));

    case (state_q)
      ST_EAV:    if (h_q == HW'(3)) state_d = ST_HBLANK;
      ST_HBLANK: if (h_q == HW'(SAV_START - 1)) state_d = ST_SAV;
      ST_SAV:    if (h_q == HW'(ACT_START - 1)) state_d = ST_ACTIVE;
      default:   if (last_h) state_d = ST_EAV;
    endcase

    case (state_q)
      ST_EAV, ST_SAV: begin
        case (code_idx)
          2'd0:       data_d = 8'hFF;
          2'd1, 2'd2: data_d = 8'h00;
          default:    data_d = xy;
        endcase
      end
      ST_HBLANK: data_d = h_q[0] ? 8'h10 : 8'h80;
      default: begin
        if (v_cur) begin
          data_d = act_odd ? 8'h10 : 8'h80;
        end else if (!act_odd) begin
          if (pix_valid) begin
            data_d = clamp(pix_data[15:8]);
            y_d    = clamp(pix_data[7:0]);
            have_d = 1'b1;
          end else begin
            // Underflow: blank this slot, never stall the stream.
            data_d  = 8'h80;
            have_d  = 1'b0;
            uflow_d = 1'b1;
          end
        end else begin
          data_d = have_q ? y_q : 8'h10;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EAV;
      h_q     <= '0;
      line_q  <= LW'(1);
      data_q  <= 8'h80;
      y_q     <= 8'h00;
      have_q  <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      line_q  <= line_d;
      data_q  <= data_d;
      y_q     <= y_d;
      have_q  <= have_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      uflow_q <= uflow_d;
    end
  end

  assign td_data     = data_q;
  assign td_hs       = hs_q;
  assign td_vs       = vs_q;
  assign frame_start = fs_q;
  assign uflow       = uflow_q;

endmodule

// File: tb/tb_bt656_video_tx.sv
// Bench for bt656_video_tx: a byte-position model of the BT.656 line/frame layout is
// checked every cycle against three parameterisations, plus pinned literal bytes.
module tb_bt656_video_tx;

  typedef struct {int ha; int hb; int vt; int f1; int f2; int v1s; int v1e; int v2s; int hs;} cfg_t;
  typedef struct {int cfg; int n; int sig; logic [7:0] val;} lit_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [15:0] pix_data;
  logic        pix_valid, uflow_clr;
  logic        ready_w [3];
  logic [7:0]  data_w  [3];
  logic        hs_w    [3];
  logic        vs_w    [3];
  logic        fs_w    [3];
  logic        uf_w    [3];

  bt656_video_tx u_a (
    .clk(clk), .reset_n(rst_n[0]), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(ready_w[0]), .uflow_clr(uflow_clr), .td_data(data_w[0]), .td_hs(hs_w[0]),
    .td_vs(vs_w[0]), .frame_start(fs_w[0]), .uflow(uf_w[0]));

  bt656_video_tx #(.H_ACTIVE_PIX(4), .H_BLANK_BYTES(8), .HS_BYTES(4)) u_b (
    .clk(clk), .reset_n(rst_n[1]), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(ready_w[1]), .uflow_clr(uflow_clr), .td_data(data_w[1]), .td_hs(hs_w[1]),
    .td_vs(vs_w[1]), .frame_start(fs_w[1]), .uflow(uf_w[1]));

  bt656_video_tx #(.H_ACTIVE_PIX(4), .H_BLANK_BYTES(8), .V_TOTAL(12), .F1_START(2),
                   .F2_START(8), .V1_START(3), .V1_END(5), .V2_START(9), .HS_BYTES(4)) u_c (
    .clk(clk), .reset_n(rst_n[2]), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_ready(ready_w[2]), .uflow_clr(uflow_clr), .td_data(data_w[2]), .td_hs(hs_w[2]),
    .td_vs(vs_w[2]), .frame_start(fs_w[2]), .uflow(uf_w[2]));

  int          errors = 0;
  int          checks = 0;
  cfg_t        cfgs [3];
  lit_t        lits [$];
  logic [15:0] pq [$];
  int          cur;
  int          m_n;
  bit          m_have;
  bit          m_uflow;
  logic [7:0]  m_y;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d byte=%0d actual=%h required=%h", name, cur, m_n, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {7'd0, act}, {7'd0, exp});
  endtask

  function automatic bit f_of(input cfg_t c, input int line);
    return (line < c.f1) || (line >= c.f2);
  endfunction

  function automatic bit v_of(input cfg_t c, input int line);
    return (line < c.v1s) || (line > c.v1e && line < c.v2s);
  endfunction

  function automatic logic [7:0] code_byte(input int idx, input bit f, input bit v, input bit h);
    if (idx == 0) return 8'hFF;
    if (idx < 3) return 8'h00;
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  function automatic logic [7:0] clamp_m(input logic [7:0] b);
    if (b == 8'h00) return 8'h01;
    else if (b == 8'hFF) return 8'hFE;
    else return b;
  endfunction

  // Is byte position n (since reset release) an even active byte of a picture line?
  task automatic slot_info(input cfg_t c, input int n, output bit sl, output int line, output int s);
    int ht, h;
    ht   = 8 + c.hb + 2 * c.ha;
    line = (n / ht) % c.vt + 1;
    h    = n % ht;
    sl   = (h >= 8 + c.hb) && !v_of(c, line) && ((h - 8 - c.hb) % 2 == 0);
    s    = (h - 8 - c.hb) / 2;
  endtask

  task automatic drive();
    bit sl;
    int line, s;
    sl = 1'b0; line = 0; s = 0;
    if (rst_n[cur]) slot_info(cfgs[cur], m_n, sl, line, s);
    pix_valid = (pq.size() > 0) && !(cur == 0 && sl && line == 20 && s >= 10 && s <= 12);
    pix_data  = (pq.size() > 0) ? pq[0] : 16'h0000;
    uflow_clr = (cur == 0 && sl && line == 20 && (s == 12 || s == 100));
  endtask

  task automatic tick();
    cfg_t c;
    int ht, line, h, a, s;
    bit f, v, sl;
    logic [7:0] e;
    c = cfgs[cur];
    @(posedge clk);
    @(negedge clk);
    if (!rst_n[cur]) begin
      chk("rst_data", data_w[cur], 8'h80);
      chk1("rst_hs", hs_w[cur], 1'b1);
      chk1("rst_vs", vs_w[cur], 1'b1);
      chk1("rst_fs", fs_w[cur], 1'b0);
      chk1("rst_uflow", uf_w[cur], 1'b0);
      chk1("rst_ready", ready_w[cur], 1'b0);
      m_n = 0; m_have = 1'b0; m_uflow = 1'b0;
    end else begin
      ht   = 8 + c.hb + 2 * c.ha;
      line = (m_n / ht) % c.vt + 1;
      h    = m_n % ht;
      f    = f_of(c, line);
      v    = v_of(c, line);
      if (uflow_clr) m_uflow = 1'b0;
      if (h < 4) e = code_byte(h, f, v, 1'b1);
      else if (h < 4 + c.hb) e = ((h - 4) % 2 == 1) ? 8'h10 : 8'h80;
      else if (h < 8 + c.hb) e = code_byte(h - 4 - c.hb, f, v, 1'b0);
      else begin
        a = h - 8 - c.hb;
        if (v) e = (a % 2 == 1) ? 8'h10 : 8'h80;
        else if (a % 2 == 0) begin
          if (pix_valid) begin
            e = clamp_m(pix_data[15:8]);
            m_y = clamp_m(pix_data[7:0]);
            m_have = 1'b1;
            void'(pq.pop_front());
          end else begin
            e = 8'h80;
            m_have = 1'b0;
            m_uflow = 1'b1;
          end
        end else e = m_have ? m_y : 8'h10;
      end
      chk("td_data", data_w[cur], e);
      chk1("td_hs", hs_w[cur], !(h < c.hs));
      chk1("td_vs", vs_w[cur], !v);
      chk1("frame_start", fs_w[cur], (h == 0 && line == 1));
      chk1("uflow", uf_w[cur], m_uflow);
      if (h >= 8 + c.hb) begin
        checks++;
        if (data_w[cur] == 8'h00 || data_w[cur] == 8'hFF) begin
          errors++;
          $display("FAIL reserved_in_active cfg=%0d byte=%0d actual=%h required=not 00/FF", cur, m_n, data_w[cur]);
        end
      end
      foreach (lits[i]) begin
        if (lits[i].cfg == cur && lits[i].n == m_n) begin
          case (lits[i].sig)
            0: chk("lit_data", data_w[cur], lits[i].val);
            1: chk1("lit_fs", fs_w[cur], lits[i].val[0]);
            2: chk1("lit_vs", vs_w[cur], lits[i].val[0]);
            default: chk1("lit_uflow", uf_w[cur], lits[i].val[0]);
          endcase
        end
      end
      m_n++;
      slot_info(c, m_n, sl, line, s);
      chk1("pix_ready", ready_w[cur], sl);
    end
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  task automatic switch_to(input int nxt);
    rst_n[cur] = 1'b0;
    cur = nxt;
    m_n = 0; m_have = 1'b0; m_uflow = 1'b0;
    rst_n[cur] = 1'b1;
  endtask

  initial begin
    cfgs[0] = '{720, 268, 525, 4, 266, 20, 263, 283, 128};
    cfgs[1] = '{4, 8, 525, 4, 266, 20, 263, 283, 4};
    cfgs[2] = '{4, 8, 12, 2, 8, 3, 5, 9, 4};
    // sig: 0 td_data, 1 frame_start, 2 td_vs, 3 uflow
    lits.push_back('{0, 0, 0, 8'hFF});      lits.push_back('{0, 1, 0, 8'h00});
    lits.push_back('{0, 2, 0, 8'h00});      lits.push_back('{0, 3, 0, 8'hF1});
    lits.push_back('{0, 0, 1, 8'h01});      lits.push_back('{0, 0, 2, 8'h00});
    lits.push_back('{0, 275, 0, 8'hEC});    lits.push_back('{0, 1716, 0, 8'hFF});
    lits.push_back('{0, 1716, 1, 8'h00});   lits.push_back('{0, 32604, 2, 8'h01});
    lits.push_back('{0, 32607, 0, 8'h9D});  lits.push_back('{0, 32879, 0, 8'h80});
    lits.push_back('{0, 32880, 0, 8'h11});  lits.push_back('{0, 32881, 0, 8'h22});
    lits.push_back('{0, 32882, 0, 8'h33});  lits.push_back('{0, 32883, 0, 8'h44});
    lits.push_back('{0, 32884, 0, 8'hFE});  lits.push_back('{0, 32885, 0, 8'h01});
    lits.push_back('{0, 32886, 0, 8'h01});  lits.push_back('{0, 32887, 0, 8'hFE});
    lits.push_back('{0, 32900, 0, 8'h80});  lits.push_back('{0, 32901, 0, 8'h10});
    lits.push_back('{0, 32900, 3, 8'h01});  lits.push_back('{0, 32904, 3, 8'h01});
    lits.push_back('{0, 32906, 0, 8'hE3});  lits.push_back('{0, 32907, 0, 8'h25});
    lits.push_back('{0, 33080, 3, 8'h00});
    lits.push_back('{1, 7179, 0, 8'hDA});   lits.push_back('{1, 7191, 0, 8'hC7});
    lits.push_back('{1, 7179, 2, 8'h01});   lits.push_back('{1, 6459, 0, 8'hF1});
    lits.push_back('{1, 6459, 2, 8'h00});   lits.push_back('{1, 6472, 0, 8'h80});
    lits.push_back('{1, 6473, 0, 8'h10});
    lits.push_back('{2, 288, 1, 8'h01});    lits.push_back('{2, 576, 1, 8'h01});
    lits.push_back('{2, 291, 0, 8'hF1});    lits.push_back('{2, 51, 0, 8'h9D});

    pq.push_back(16'h1122); pq.push_back(16'h3344);
    pq.push_back(16'hFF00); pq.push_back(16'h00FF);
    for (int i = 0; i < 800; i++) pq.push_back({8'(i * 37 + 5), 8'(i * 91 + 3)});

    rst_n = 3'b000; pix_valid = 1'b0; pix_data = 16'h0; uflow_clr = 1'b0;
    cur = 0; m_n = 0; m_have = 1'b0; m_uflow = 1'b0; m_y = 8'h00;

    repeat (3) tick();
    rst_n[0] = 1'b1;
    // Run into line 21, stopping with a valid pixel offered at active slot 25.
    repeat (20 * 1716 + 276 + 50) step();
    drive();
    #1 rst_n[0] = 1'b0;
    #1;
    chk("async_rst_data", data_w[0], 8'h80);
    chk1("async_rst_hs", hs_w[0], 1'b1);
    chk1("async_rst_vs", vs_w[0], 1'b1);
    chk1("async_rst_ready", ready_w[0], 1'b0);
    chk1("async_rst_uflow", uf_w[0], 1'b0);
    repeat (3) step();
    rst_n[0] = 1'b1;
    repeat (1716 + 8) step();

    switch_to(1);
    repeat (300 * 24 + 8) step();

    switch_to(2);
    pq.delete();
    for (int i = 0; i < 20; i++) pq.push_back({8'(i * 29 + 1), 8'(i * 53 + 7)});
    repeat (2 * 12 * 24 + 30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
